// File: rtl/subtractor_8bit.sv
// subtractor_8bit: registered two's-complement subtractor with status flags.
// result = a - b, formed as a + ~b + 1 at WIDTH+1 bits, presented one clock
// after the operands together with out_valid, borrow, overflow, zero and
// negative.
//
// Optional build macro SUB_SATURATE_EN adds a 'sat' input. When sat = 1 and
// the unsigned subtraction borrows, result clamps to zero. borrow still
// reports the borrow, and zero/negative follow the clamped result. Without
// the macro the port does not exist and results always wrap.
module subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
`ifdef SUB_SATURATE_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int MSB = WIDTH - 1;

    // Signed overflow of a - b: the operands differ in sign and the
    // wrapped difference has a different sign from the minuend.
    function automatic logic sub_overflow(
        input logic signed [WIDTH-1:0] op_a,
        input logic signed [WIDTH-1:0] op_b,
        input logic signed [WIDTH-1:0] dif
    );
        sub_overflow = ((op_a < 0) != (op_b < 0)) && ((dif < 0) != (op_a < 0));
    endfunction

    // Unsigned saturation: a borrowing subtraction clamps to zero when
    // saturation is requested, otherwise the wrapped value passes through.
    function automatic logic [WIDTH-1:0] sat_clamp(
        input logic [WIDTH-1:0] dif,
        input logic             brw,
        input logic             sat_en
    );
        sat_clamp = (sat_en && brw) ? '0 : dif;
    endfunction

    logic                    sat_p0;
    logic signed [WIDTH-1:0] a_s_p0;
    logic signed [WIDTH-1:0] b_s_p0;
    logic        [WIDTH:0]   diff_p0;
    logic                    borrow_p0;
    logic signed [WIDTH-1:0] wrap_p0;
    logic        [WIDTH-1:0] res_p0;
    logic                    ovf_p0;

    logic        [WIDTH-1:0] result_p1;
    logic                    vld_p1;
    logic                    borrow_p1;
    logic                    overflow_p1;
    logic                    zero_p1;
    logic                    negative_p1;

`ifdef SUB_SATURATE_EN
    assign sat_p0 = sat;
`else
    assign sat_p0 = 1'b0;
`endif

    // Stage p0: combinational difference and flags from the current operands.
    // Overflow describes the wrapped signed arithmetic, so it is taken from
    // the unclamped difference.
    always_comb begin
        a_s_p0    = a;
        b_s_p0    = b;
        diff_p0   = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
        borrow_p0 = ~diff_p0[WIDTH];
        wrap_p0   = diff_p0[WIDTH-1:0];
        ovf_p0    = sub_overflow(a_s_p0, b_s_p0, wrap_p0);
        res_p0    = sat_clamp(diff_p0[WIDTH-1:0], borrow_p0, sat_p0);
    end

    // Stage p1: output register; reset wins, idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_p1   <= '0;
            vld_p1      <= 1'b0;
            borrow_p1   <= 1'b0;
            overflow_p1 <= 1'b0;
            zero_p1     <= 1'b1;
            negative_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                result_p1   <= res_p0;
                borrow_p1   <= borrow_p0;
                overflow_p1 <= ovf_p0;
                zero_p1     <= (res_p0 == '0);
                negative_p1 <= res_p0[MSB];
            end
        end
    end

    assign result    = result_p1;
    assign out_valid = vld_p1;
    assign borrow    = borrow_p1;
    assign overflow  = overflow_p1;
    assign zero      = zero_p1;
    assign negative  = negative_p1;

endmodule

// File: tb/tb_subtractor_8bit.sv
// Scoreboard bench for subtractor_8bit: directed vectors push their
// hand-computed responses into a queue, a monitor pops and compares on every
// out_valid. Reset and idle-hold states are checked directly.
module tb_subtractor_8bit;

    typedef struct {
        logic [7:0] res;
        logic       brw;
        logic       ovf;
        logic       zro;
        logic       neg;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       sat;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       out_valid;
    logic       borrow;
    logic       overflow;
    logic       zero;
    logic       negative;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    subtractor_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
`ifdef SUB_SATURATE_EN
        .sat       (sat),
`endif
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
        end
    endtask

    // Drive one operation for one edge and record its expected response.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] er,
                         input logic eb, input logic eo, input logic ez, input logic en);
        exp_t e;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        e.res = er; e.brw = eb; e.ovf = eo; e.zro = ez; e.neg = en;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got result 0x%02h with no pending operation", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result",   result,          e.res);
                chk("borrow",   {7'd0, borrow},   {7'd0, e.brw});
                chk("overflow", {7'd0, overflow}, {7'd0, e.ovf});
                chk("zero",     {7'd0, zero},     {7'd0, e.zro});
                chk("negative", {7'd0, negative}, {7'd0, e.neg});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        sat      = 1'b0;
        a        = 8'd2;
        b        = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result",    result,             8'h00);
        chk("rst_zero",      {7'd0, zero},       8'd1);
        chk("rst_out_valid", {7'd0, out_valid},  8'd0);
        chk("rst_borrow",    {7'd0, borrow},     8'd0);
        chk("rst_overflow",  {7'd0, overflow},   8'd0);
        chk("rst_negative",  {7'd0, negative},   8'd0);

        reset = 1'b1;
        //     a      b      result borrow ovf zero neg
        issue(8'h09, 8'h06, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(8'h02, 8'h03, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef SUB_SATURATE_EN
        sat = 1'b1;
        issue(8'h02, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        sat = 1'b0;
`endif
        issue(8'h05, 8'h08, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(8'h02, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(8'h07, 8'h07, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Idle cycle: outputs hold the 7 - 7 response, out_valid drops.
        in_valid = 1'b0;
        a        = 8'h55;
        b        = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        chk("idle_out_valid", {7'd0, out_valid}, 8'd0);
        chk("idle_result",    result,            8'h00);
        chk("idle_zero",      {7'd0, zero},      8'd1);
        chk("idle_overflow",  {7'd0, overflow},  8'd0);
        @(posedge clk);
        #1;

        // Launch, then reset on the following edge while in_valid stays high.
        issue(8'h09, 8'h06, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b1;
        a        = 8'h09;
        b        = 8'h06;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("midrst_result",    result,            8'h00);
        chk("midrst_zero",      {7'd0, zero},      8'd1);

        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 8'h05;
        b        = 8'h08;
        @(posedge clk);
        @(negedge clk);
        chk("post_out_valid", {7'd0, out_valid}, 8'd0);
        chk("post_result",    result,            8'h00);
        chk("post_borrow",    {7'd0, borrow},    8'd0);
        chk("post_zero",      {7'd0, zero},      8'd1);

        repeat (2) @(posedge clk);
        chk("queue_drained", 8'(q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
